dm_arbiter: RTL and testbench

//  Two-requester arbiter and sequencer for the single-port 128x32 data memory (datamemory).

---
 rtl/dm_arb_pkg.sv | 17 +
 rtl/dm_arbiter_if.sv | 20 ++
 rtl/dm_arbiter_rr_pick2.sv | 22 ++
 rtl/dm_arbiter.sv | 111 +++++++++++
 tb/tb_dm_arbiter.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/dm_arb_pkg.sv
// Shared types and defaults for the two-port data-memory arbiter.
package dm_arb_pkg;

  localparam int DEF_ADDR_W = 7;
  localparam int DEF_DATA_W = 32;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_t;

endpackage

// File: rtl/dm_arbiter_if.sv
// One requester's handshake bundle: request/command towards the arbiter, grant/read data back.
interface dm_arbiter_if
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/dm_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker: a tie goes to the port that was not served last.
module rr_pick2
  import dm_arb_pkg::*;
(
  input  logic  req0,
  input  logic  req1,
  input  port_t last_owner,
  output logic  valid,
  output port_t owner
);

  always_comb begin
    valid = req0 | req1;
    owner = PORT0;
    if (req0 && req1) begin
      owner = (last_owner == PORT0) ? PORT1 : PORT0;
    end else if (req1) begin
      owner = PORT1;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Arbiter/sequencer for the single-port data memory: one access per two cycles,
// round-robin between the CPU port (port0) and the loader port (port1).
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
)(
  input  logic              clk,
  input  logic              reset,
  dm_arbiter_if.slave       port0,
  dm_arbiter_if.slave       port1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  state_t            state, state_nxt;
  port_t             last_owner, owner, pick_owner;
  logic              pick_vld;
  logic              take;
  logic              rd_done;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  rr_pick2 u_pick (
    .req0       (port0.req),
    .req1       (port1.req),
    .last_owner (last_owner),
    .valid      (pick_vld),
    .owner      (pick_owner)
  );

  assign take    = (state == ST_IDLE) && pick_vld;
  assign rd_done = (state == ST_ACCESS) && !lat_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_owner <= PORT1;
      owner      <= PORT0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      rvalid0_q <= rd_done && (owner == PORT0);
      rvalid1_q <= rd_done && (owner == PORT1);
      if (take) begin
        owner      <= pick_owner;
        last_owner <= pick_owner;
      end
    end
  end

  // Command latch: only the winner's request is captured, so the memory sees stable values.
  always_ff @(posedge clk) begin
    if (take) begin
      lat_we    <= (pick_owner == PORT1) ? port1.we    : port0.we;
      lat_addr  <= (pick_owner == PORT1) ? port1.addr  : port0.addr;
      lat_wdata <= (pick_owner == PORT1) ? port1.wdata : port0.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if (rd_done) begin
      if (owner == PORT0) rdata0_q <= mem_dout;
      else                rdata1_q <= mem_dout;
    end
  end

  // Reset gates the access cycle combinationally so a mid-access reset never writes.
  always_comb begin
    state_nxt = state;
    mem_addr  = lat_addr;
    mem_din   = lat_wdata;
    mem_we    = 1'b0;
    port0.gnt = 1'b0;
    port1.gnt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_vld) state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        state_nxt = ST_IDLE;
        mem_we    = lat_we && !reset;
        port0.gnt = (owner == PORT0) && !reset;
        port1.gnt = (owner == PORT1) && !reset;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign port0.rvalid = rvalid0_q;
  assign port1.rvalid = rvalid1_q;
  assign port0.rdata  = rdata0_q;
  assign port1.rdata  = rdata1_q;

  // A requester that loses arbitration must keep its request up until served.
  a_hold0: assert property (@(posedge clk) disable iff (reset)
    (take && port0.req && pick_owner != PORT0) |=> port0.req);
  a_hold1: assert property (@(posedge clk) disable iff (reset)
    (take && port1.req && pick_owner != PORT1) |=> port1.req);

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural 128x32 data memory attached.
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [6:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic [31:0] mem [0:127];
  int          errors = 0;
  int          checks = 0;

  dm_arbiter_if #(.ADDR_W(7), .DATA_W(32)) p0_if ();
  dm_arbiter_if #(.ADDR_W(7), .DATA_W(32)) p1_if ();

  dm_arbiter #(.ADDR_W(7), .DATA_W(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .port0    (p0_if.slave),
    .port1    (p1_if.slave),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_din  (mem_din),
    .mem_dout (mem_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_din;
    end else if (load) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'd0;
      mem[7] <= 32'd15;
      mem[9] <= 32'd55;
    end
  end
  assign mem_dout = mem[mem_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    load  = 1'b1;
    p0_if.req = 1'b0; p0_if.we = 1'b0; p0_if.addr = '0; p0_if.wdata = '0;
    p1_if.req = 1'b0; p1_if.we = 1'b0; p1_if.addr = '0; p1_if.wdata = '0;
    tick();
    tick();
    load = 1'b0;
    chk("rst_gnt0", p0_if.gnt, 0);
    chk("rst_gnt1", p1_if.gnt, 0);
    chk("rst_rvalid0", p0_if.rvalid, 0);
    chk("rst_rvalid1", p1_if.rvalid, 0);
    chk("rst_rdata0", p0_if.rdata, 0);
    chk("rst_rdata1", p1_if.rdata, 0);
    chk("rst_mem_we", mem_we, 0);
    reset = 1'b0;

    // 1: port 0 write 20 @5, then read back
    p0_if.req = 1'b1; p0_if.we = 1'b1; p0_if.addr = 7'd5; p0_if.wdata = 32'd20;
    tick();
    chk("t1_wr_gnt0", p0_if.gnt, 1);
    chk("t1_wr_gnt1", p1_if.gnt, 0);
    chk("t1_wr_mem_we", mem_we, 1);
    chk("t1_wr_mem_addr", mem_addr, 5);
    chk("t1_wr_mem_din", mem_din, 20);
    tick();
    chk("t1_wr_gnt_end", p0_if.gnt, 0);
    chk("t1_wr_no_rvalid", p0_if.rvalid, 0);
    p0_if.we = 1'b0;
    tick();
    chk("t1_rd_gnt0", p0_if.gnt, 1);
    chk("t1_rd_mem_we", mem_we, 0);
    tick();
    chk("t1_rd_rvalid0", p0_if.rvalid, 1);
    chk("t1_rd_rdata0", p0_if.rdata, 20);
    chk("t1_rd_gnt_end", p0_if.gnt, 0);
    p0_if.req = 1'b0;
    tick();
    chk("t1_rvalid_pulse", p0_if.rvalid, 0);
    chk("t1_rdata_hold", p0_if.rdata, 20);

    // reset so the next tie starts from the reset ownership
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_rdata0", p0_if.rdata, 0);

    // 2: simultaneous reads, port 0 first
    p0_if.req = 1'b1; p0_if.we = 1'b0; p0_if.addr = 7'd5;
    p1_if.req = 1'b1; p1_if.we = 1'b0; p1_if.addr = 7'd7;
    tick();
    chk("t2_gnt0", p0_if.gnt, 1);
    chk("t2_gnt1_wait", p1_if.gnt, 0);
    tick();
    chk("t2_rvalid0", p0_if.rvalid, 1);
    chk("t2_rdata0", p0_if.rdata, 20);
    chk("t2_gnt1_idle", p1_if.gnt, 0);
    p0_if.req = 1'b0;
    tick();
    chk("t2_gnt1", p1_if.gnt, 1);
    chk("t2_gnt0_off", p0_if.gnt, 0);
    tick();
    chk("t2_rvalid1", p1_if.rvalid, 1);
    chk("t2_rdata1", p1_if.rdata, 15);
    chk("t2_rdata0_kept", p0_if.rdata, 20);
    p1_if.req = 1'b0;

    // 3: both held for 8 accesses -> strict alternation, every other cycle
    p0_if.req = 1'b1; p0_if.addr = 7'd5;
    p1_if.req = 1'b1; p1_if.addr = 7'd7;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("t3_gnt0_c%0d", k), p0_if.gnt, (k % 4 == 1) ? 1 : 0);
      chk($sformatf("t3_gnt1_c%0d", k), p1_if.gnt, (k % 4 == 3) ? 1 : 0);
    end
    p0_if.req = 1'b0;
    p1_if.req = 1'b0;

    // 4: port 1 write 30 @7 with a port 0 read @7 queued behind it
    p1_if.req = 1'b1; p1_if.we = 1'b1; p1_if.addr = 7'd7; p1_if.wdata = 32'd30;
    tick();
    chk("t4_gnt1", p1_if.gnt, 1);
    chk("t4_mem_we", mem_we, 1);
    p0_if.req = 1'b1; p0_if.we = 1'b0; p0_if.addr = 7'd7;
    tick();
    chk("t4_rvalid1_wr", p1_if.rvalid, 0);
    p1_if.req = 1'b0;
    tick();
    chk("t4_gnt0", p0_if.gnt, 1);
    tick();
    chk("t4_rvalid0", p0_if.rvalid, 1);
    chk("t4_rdata0", p0_if.rdata, 30);
    chk("t4_rdata1_kept", p1_if.rdata, 15);
    chk("t4_rvalid1", p1_if.rvalid, 0);
    p0_if.req = 1'b0;
    tick();

    // 5: reset lands in the access cycle of a write 99 @9
    p0_if.req = 1'b1; p0_if.we = 1'b1; p0_if.addr = 7'd9; p0_if.wdata = 32'd99;
    tick();
    chk("t5_gnt0_pre", p0_if.gnt, 1);
    reset = 1'b1;
    #1;
    chk("t5_mem_we_gated", mem_we, 0);
    chk("t5_gnt0_gated", p0_if.gnt, 0);
    p0_if.req = 1'b0;
    tick();
    reset = 1'b0;
    chk("t5_mem9", mem[9], 55);
    chk("t5_rvalid0", p0_if.rvalid, 0);
    chk("t5_rdata0", p0_if.rdata, 0);
    chk("t5_rdata1", p1_if.rdata, 0);
    tick();
    chk("t5_idle_gnt0", p0_if.gnt, 0);
    chk("t5_idle_gnt1", p1_if.gnt, 0);
    chk("t5_idle_mem_we", mem_we, 0);

    // 6: write-only access leaves read data alone
    p0_if.req = 1'b1; p0_if.we = 1'b0; p0_if.addr = 7'd5;
    tick();
    tick();
    chk("t6_pre_rdata0", p0_if.rdata, 20);
    p0_if.we = 1'b1; p0_if.addr = 7'd3; p0_if.wdata = 32'd42;
    tick();
    chk("t6_gnt0", p0_if.gnt, 1);
    chk("t6_mem_we", mem_we, 1);
    tick();
    chk("t6_rvalid0", p0_if.rvalid, 0);
    chk("t6_rdata0_hold", p0_if.rdata, 20);
    p0_if.req = 1'b0;
    tick();
    chk("t6_rvalid0_after", p0_if.rvalid, 0);
    chk("t6_mem3", mem[3], 42);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
